// File: rtl/tile_painter.sv
// Purpose: paints changed grid cells (and full-screen clears) as a stream of RGB565 pixels.
// Latency: first pixel presented one cycle after entering CLEAR/PAINT, then one pixel per accepted cycle.
// Backpressure: pix_ready low holds pix_x/pix_y/pix_color stable; enable stays low until the burst ends.
module tile_painter #(
    parameter int TILE = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        diff,
    input  logic [2:0]  obj_code,
    input  logic [3:0]  x,
    input  logic [3:0]  y,
    input  logic        clear_req,
    input  logic        pix_ready,
    output logic        enable,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        busy,
    output logic        sweep_done,
    output logic [7:0]  dirty_last
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_SCAN  = 2'd1,
        ST_PAINT = 2'd2
    } state_t;

    localparam logic [7:0] TILE_W    = 8'(TILE);
    localparam logic [7:0] TILE_MAX  = 8'(TILE - 1);
    localparam logic [7:0] CLR_X_MAX = 8'(16 * TILE - 1);
    localparam logic [7:0] CLR_Y_MAX = 8'(12 * TILE - 1);

    // Object code to RGB565 colour; unused codes paint black.
    function automatic logic [15:0] color_map(input logic [2:0] code);
        logic [15:0] c;
        case (code)
            3'd1:    c = 16'h07E0;
            3'd2:    c = 16'h03E0;
            3'd3:    c = 16'hF800;
            3'd4:    c = 16'h8410;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    state_t      state_q, state_d;
    // Pixel index of the currently presented pixel within the burst (screen in CLEAR, tile in PAINT).
    logic [7:0]  cnt_x_q, cnt_x_d;
    logic [7:0]  cnt_y_q, cnt_y_d;
    // Pixel origin and colour of the burst; zero origin and black for a clear.
    logic [7:0]  base_x_q, base_x_d;
    logic [7:0]  base_y_q, base_y_d;
    logic [15:0] color_q, color_d;
    logic        pix_valid_q, pix_valid_d;
    logic [7:0]  pix_x_q, pix_x_d;
    logic [7:0]  pix_y_q, pix_y_d;
    logic [15:0] pix_color_q, pix_color_d;
    logic        sweep_done_q, sweep_done_d;
    logic [7:0]  dirty_cnt_q, dirty_cnt_d;
    logic [7:0]  dirty_last_q, dirty_last_d;

    logic        capture;
    logic [7:0]  last_x, last_y;
    logic [7:0]  dirty_next;

    // Next-state, pixel sequencing and sweep bookkeeping.
    always_comb begin
        state_d      = state_q;
        cnt_x_d      = cnt_x_q;
        cnt_y_d      = cnt_y_q;
        base_x_d     = base_x_q;
        base_y_d     = base_y_q;
        color_d      = color_q;
        pix_valid_d  = pix_valid_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_color_d  = pix_color_q;
        capture      = 1'b0;
        last_x       = (state_q == ST_CLEAR) ? CLR_X_MAX : TILE_MAX;
        last_y       = (state_q == ST_CLEAR) ? CLR_Y_MAX : TILE_MAX;

        case (state_q)
            ST_SCAN: begin
                if (diff) begin
                    // A changed cell wins over a pending clear request.
                    capture  = 1'b1;
                    state_d  = ST_PAINT;
                    base_x_d = {4'b0000, x} * TILE_W;
                    base_y_d = {4'b0000, y} * TILE_W;
                    color_d  = color_map(obj_code);
                    cnt_x_d  = 8'd0;
                    cnt_y_d  = 8'd0;
                end else if (clear_req) begin
                    state_d  = ST_CLEAR;
                    base_x_d = 8'd0;
                    base_y_d = 8'd0;
                    color_d  = 16'h0000;
                    cnt_x_d  = 8'd0;
                    cnt_y_d  = 8'd0;
                end
            end
            ST_CLEAR, ST_PAINT: begin
                if (!pix_valid_q) begin
                    // Entry cycle: present the first pixel of the burst.
                    pix_valid_d = 1'b1;
                    pix_x_d     = base_x_q + cnt_x_q;
                    pix_y_d     = base_y_q + cnt_y_q;
                    pix_color_d = color_q;
                end else if (pix_ready) begin
                    if (cnt_x_q == last_x && cnt_y_q == last_y) begin
                        state_d     = ST_SCAN;
                        pix_valid_d = 1'b0;
                        cnt_x_d     = 8'd0;
                        cnt_y_d     = 8'd0;
                    end else begin
                        if (cnt_x_q == last_x) begin
                            cnt_x_d = 8'd0;
                            cnt_y_d = cnt_y_q + 8'd1;
                        end else begin
                            cnt_x_d = cnt_x_q + 8'd1;
                        end
                        pix_x_d = base_x_q + cnt_x_d;
                        pix_y_d = base_y_q + cnt_y_d;
                    end
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                pix_valid_d = 1'b0;
                cnt_x_d     = 8'd0;
                cnt_y_d     = 8'd0;
                base_x_d    = 8'd0;
                base_y_d    = 8'd0;
                color_d     = 16'h0000;
            end
        endcase

        // The scanner has wrapped once it is allowed past the last cell.
        sweep_done_d = (state_q == ST_SCAN) && (x == 4'd15) && (y == 4'd11);
        dirty_next   = dirty_cnt_q + {7'd0, capture};
        if (sweep_done_d) begin
            dirty_last_d = dirty_next;
            dirty_cnt_d  = 8'd0;
        end else begin
            dirty_last_d = dirty_last_q;
            dirty_cnt_d  = dirty_next;
        end
    end

    // State and registered outputs; reset aborts any burst and restarts the clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_CLEAR;
            cnt_x_q      <= 8'd0;
            cnt_y_q      <= 8'd0;
            base_x_q     <= 8'd0;
            base_y_q     <= 8'd0;
            color_q      <= 16'h0000;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= 8'd0;
            pix_y_q      <= 8'd0;
            pix_color_q  <= 16'h0000;
            sweep_done_q <= 1'b0;
            dirty_cnt_q  <= 8'd0;
            dirty_last_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_x_q      <= cnt_x_d;
            cnt_y_q      <= cnt_y_d;
            base_x_q     <= base_x_d;
            base_y_q     <= base_y_d;
            color_q      <= color_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_color_q  <= pix_color_d;
            sweep_done_q <= sweep_done_d;
            dirty_cnt_q  <= dirty_cnt_d;
            dirty_last_q <= dirty_last_d;
        end
    end

    assign enable     = (state_q == ST_SCAN);
    assign busy       = (state_q != ST_SCAN);
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_color  = pix_color_q;
    assign sweep_done = sweep_done_q;
    assign dirty_last = dirty_last_q;

endmodule

// File: doc/tile_painter.md
TILE_PAINTER -- requirements
Module: tile_painter

Interface
REQ-001 Parameter TILE, default 8, pixel edge length of one grid cell; legal range 1..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 nrst  input  1  asynchronous, active-low reset.
REQ-004 diff  input  1  current grid cell changed; valid the same cycle as obj_code/x/y.
REQ-005 obj_code  input  3  new cell content: 0 blank, 1 head, 2 body, 3 apple, 4 border.
REQ-006 x  input  4  current cell column, 0..15.
REQ-007 y  input  4  current cell row, 0..11.
REQ-008 clear_req  input  1  request a full-screen clear; level-sampled in SCAN only.
REQ-009 pix_ready  input  1  display sink accepts the presented pixel this cycle.
REQ-010 enable  output  1  advance permission to the upstream cell scanner.
REQ-011 pix_valid  output  1  pix_x/pix_y/pix_color hold a pixel to write.
REQ-012 pix_x  output  8  pixel column.
REQ-013 pix_y  output  8  pixel row.
REQ-014 pix_color  output  16  RGB565 pixel colour.
REQ-015 busy  output  1  high in every state except SCAN.
REQ-016 sweep_done  output  1  one-cycle pulse when the scanner wraps from cell (15,11).
REQ-017 dirty_last  output  8  count of cells painted during the last completed sweep.

Function
REQ-018 FSM states CLEAR, SCAN, PAINT; all outputs are registered or decoded from registered state only.
REQ-019 CLEAR: emit every pixel from (0,0) to (16*TILE-1, 12*TILE-1), colour 0x0000, x fastest; after the last pixel is accepted, go to SCAN.
REQ-020 SCAN: enable=1, pix_valid=0; on a clock edge with diff=1, capture obj_code, x and y, zero the pixel counters, and go to PAINT.
REQ-021 SCAN with diff=0 and clear_req=1: go to CLEAR; diff=1 takes priority over clear_req in the same cycle.
REQ-022 PAINT: enable=0; emit TILE*TILE pixels with pix_x = cap_x*TILE + px and pix_y = cap_y*TILE + py; px runs fastest, 0..TILE-1.
REQ-023 Colour map: 0 -> 0x0000, 1 -> 0x07E0, 2 -> 0x03E0, 3 -> 0xF800, 4 -> 0x8410, 5..7 -> 0x0000.
REQ-024 Handshake: a pixel transfers on a cycle with pix_valid=1 and pix_ready=1; pix_x/pix_y/pix_color are held stable while pix_valid=1 and pix_ready=0; no pixel is skipped or repeated.
REQ-025 pix_valid is asserted the cycle after entering CLEAR or PAINT; back-to-back pixels at one pixel per cycle while pix_ready=1.
REQ-026 The last PAINT pixel accepted -> SCAN on the next cycle; enable is 0 during that transition cycle.
REQ-027 diff and clear_req are ignored outside SCAN.
REQ-028 sweep_done pulses in the cycle after a SCAN cycle with enable=1 and x=15, y=11.
REQ-029 dirty counter (8 bit) increments on each PAINT entry.
REQ-030 On the sweep_done pulse, dirty_last is loaded with the dirty count including any capture in that same cycle, and the counter restarts at 0.
REQ-031 Pixel coordinate arithmetic is 8-bit unsigned; no overflow for legal TILE values.

Reset
REQ-032 nrst low: state CLEAR, enable=0, pix_valid=0, pix_x=0, pix_y=0, pix_color=0, busy=1, sweep_done=0, dirty_last=0, all counters 0.
REQ-033 Reset asserted mid-PAINT or mid-CLEAR aborts the transfer immediately; after release the block restarts the full CLEAR from pixel (0,0).

Verification
REQ-034 Release reset, pix_ready=1, TILE=8 -> 12288 pixels of colour 0x0000, last at (127,95), then enable=1 with busy=0.
REQ-035 In SCAN, diff=1, obj_code=3, x=2, y=1 -> 64 pixels, colour 0xF800, pix_x 16..23, pix_y 8..15, enable=0 throughout, then back to SCAN.
REQ-036 During PAINT, hold pix_ready=0 for 5 cycles mid-tile -> outputs frozen; total accepted pixels still exactly 64, none duplicated.
REQ-037 One full sweep containing 3 diff pulses -> sweep_done pulses once, dirty_last=3.
REQ-038 In SCAN, diff=1 and clear_req=1 in the same cycle -> tile painted first, then no CLEAR unless clear_req is still high in SCAN.
REQ-039 nrst pulsed low at pixel 30 of a PAINT -> all outputs return to reset values; CLEAR restarts at (0,0).
